// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (fetch/data) arbiter in front of a single-ported memory
// Data requests normally win; a starve counter forces a fetch grant after STARVE_MAX denials.
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned STARVE_MAX  = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,

    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_valid,
    output logic [31:0] dm_rdata,

    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        DM_ACC = 2'd2
    } state_t;

    localparam logic [3:0] LAST_WAIT  = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state;
    state_t      nextState;
    logic [3:0]  waitCnt;
    logic [3:0]  starveCnt;
    logic [31:0] latAddr;
    logic [31:0] latWdata;
    logic        latWe;
    logic        ifValidQ;
    logic        dmValidQ;
    logic [31:0] ifRdataQ;
    logic [31:0] dmRdataQ;

    logic        accDone;
    logic        fetchStarved;
    logic        pickDm;
    logic        pickIf;

    // Arbitration only happens in IDLE; requests seen during an access are ignored.
    assign accDone      = (state != IDLE) && (waitCnt == LAST_WAIT);
    assign fetchStarved = (starveCnt == STARVE_LIM) && if_req;
    assign pickDm       = (state == IDLE) && dm_req && !fetchStarved;
    assign pickIf       = (state == IDLE) && if_req && !pickDm;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (pickDm) begin
                    nextState = DM_ACC;
                end else if (pickIf) begin
                    nextState = IF_ACC;
                end
            end
            IF_ACC, DM_ACC: begin
                if (accDone) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        if_gnt    = 1'b0;
        dm_gnt    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        case (state)
            IF_ACC: begin
                if_gnt   = (waitCnt == 4'd0);
                mem_en   = 1'b1;
                mem_addr = latAddr;
            end
            DM_ACC: begin
                dm_gnt    = (waitCnt == 4'd0);
                mem_en    = 1'b1;
                mem_we    = latWe;
                mem_addr  = latAddr;
                mem_wdata = latWdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waitCnt <= 4'd0;
        end else if (state == IDLE || accDone) begin
            waitCnt <= 4'd0;
        end else begin
            waitCnt <= waitCnt + 4'd1;
        end
    end

    // Winner's request is captured on the grant edge so requesters may change freely afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            latAddr  <= 32'd0;
            latWdata <= 32'd0;
            latWe    <= 1'b0;
        end else if (pickDm) begin
            latAddr  <= dm_addr;
            latWdata <= dm_wdata;
            latWe    <= dm_we;
        end else if (pickIf) begin
            latAddr  <= if_addr;
            latWdata <= 32'd0;
            latWe    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starveCnt <= 4'd0;
        end else if (pickIf) begin
            starveCnt <= 4'd0;
        end else if (pickDm && if_req && (starveCnt < STARVE_LIM)) begin
            starveCnt <= starveCnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ifValidQ <= 1'b0;
            dmValidQ <= 1'b0;
            ifRdataQ <= 32'd0;
            dmRdataQ <= 32'd0;
        end else begin
            ifValidQ <= accDone && (state == IF_ACC);
            dmValidQ <= accDone && (state == DM_ACC);
            if (accDone && (state == IF_ACC)) begin
                ifRdataQ <= mem_rdata;
            end
            // Stores leave the last load value intact.
            if (accDone && (state == DM_ACC) && !latWe) begin
                dmRdataQ <= mem_rdata;
            end
        end
    end

    assign if_valid = ifValidQ;
    assign dm_valid = dmValidQ;
    assign if_rdata = ifRdataQ;
    assign dm_rdata = dmRdataQ;

endmodule
